// File: rtl/any1_rob_queue.sv
// any1_rob_queue: in-order reorder queue for the ANY-1 core.
// Entries are allocated in program order and written back out of order by
// NFU functional units. Up to CMT_W in-order entries retire per cycle. The
// oldest faulting entry raises a precise exception, and the whole queue is
// flushed at that edge.
module any1_rob_queue #(
  parameter int ENTRIES = 8,
  parameter int NFU     = 2,
  parameter int CMT_W   = 2,
  parameter int DATA_W  = 64,
  parameter int AWID    = 32,
  localparam int RIDW   = $clog2(ENTRIES)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    alloc_v_i,
  output logic                    alloc_rdy_o,
  output logic [RIDW-1:0]         alloc_rid_o,
  input  logic [7:0]              alloc_rt_i,
  input  logic                    alloc_rfwr_i,
  input  logic [AWID-1:0]         alloc_ip_i,
  input  logic [NFU-1:0]          wb_v_i,
  input  logic [NFU*RIDW-1:0]     wb_rid_i,
  input  logic [NFU*DATA_W-1:0]   wb_res_i,
  input  logic [NFU*8-1:0]        wb_cause_i,
  input  logic                    flush_i,
  output logic [CMT_W-1:0]        cmt_v_o,
  output logic [CMT_W*8-1:0]      cmt_rt_o,
  output logic [CMT_W-1:0]        cmt_rfwr_o,
  output logic [CMT_W*DATA_W-1:0] cmt_res_o,
  output logic                    exc_v_o,
  output logic [7:0]              exc_cause_o,
  output logic [AWID-1:0]         exc_ip_o,
  output logic [RIDW:0]           count_o
);

  logic [RIDW:0]        head_q, head_d, tail_q, tail_d;
  logic [ENTRIES-1:0]   v_q, v_d, done_q, done_d, rfwr_q, rfwr_d;
  logic [7:0]           rt_q    [ENTRIES];
  logic [7:0]           rt_d    [ENTRIES];
  logic [7:0]           cause_q [ENTRIES];
  logic [7:0]           cause_d [ENTRIES];
  logic [AWID-1:0]      ip_q    [ENTRIES];
  logic [AWID-1:0]      ip_d    [ENTRIES];
  logic [DATA_W-1:0]    res_q   [ENTRIES];
  logic [DATA_W-1:0]    res_d   [ENTRIES];

  logic                 full, alloc_go, flush_all, run;
  logic [RIDW:0]        ncmt;
  logic [RIDW-1:0]      cidx, widx, tidx;

  // Wrap bit distinguishes full from empty when the low index bits match.
  assign count_o     = tail_q - head_q;
  assign full        = (count_o == (RIDW+1)'(ENTRIES));
  assign alloc_rdy_o = !full;
  assign alloc_rid_o = tail_q[RIDW-1:0];
  assign alloc_go    = alloc_v_i && !full;
  assign flush_all   = flush_i || exc_v_o;

  // Scan lanes from head: retire done/clean entries until the first
  // not-done or faulting one; a fault there becomes the exception.
  always_comb begin
    cmt_v_o     = '0;
    cmt_rt_o    = '0;
    cmt_rfwr_o  = '0;
    cmt_res_o   = '0;
    exc_v_o     = 1'b0;
    exc_cause_o = '0;
    exc_ip_o    = '0;
    ncmt        = '0;
    cidx        = '0;
    run         = 1'b1;
    for (int k = 0; k < CMT_W; k++) begin
      cidx = head_q[RIDW-1:0] + RIDW'(k);
      if (run && v_q[cidx] && done_q[cidx]) begin
        if (cause_q[cidx] == 8'h00) begin
          cmt_v_o[k]                 = 1'b1;
          cmt_rt_o[k*8 +: 8]         = rt_q[cidx];
          cmt_rfwr_o[k]              = rfwr_q[cidx];
          cmt_res_o[k*DATA_W +: DATA_W] = res_q[cidx];
          ncmt                       = ncmt + (RIDW+1)'(1);
        end else begin
          exc_v_o     = 1'b1;
          exc_cause_o = cause_q[cidx];
          exc_ip_o    = ip_q[cidx];
          run         = 1'b0;
        end
      end else begin
        run = 1'b0;
      end
    end
  end

  // Next state: flush wins over everything; otherwise writeback (higher
  // port index overrides lower), retire committed entries, then allocate.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    v_d     = v_q;
    done_d  = done_q;
    rfwr_d  = rfwr_q;
    rt_d    = rt_q;
    cause_d = cause_q;
    ip_d    = ip_q;
    res_d   = res_q;
    widx    = '0;
    tidx    = '0;
    if (flush_all) begin
      v_d    = '0;
      done_d = '0;
      head_d = '0;
      tail_d = '0;
    end else begin
      for (int p = 0; p < NFU; p++) begin
        widx = wb_rid_i[p*RIDW +: RIDW];
        if (wb_v_i[p] && v_q[widx]) begin
          done_d[widx]  = 1'b1;
          res_d[widx]   = wb_res_i[p*DATA_W +: DATA_W];
          cause_d[widx] = wb_cause_i[p*8 +: 8];
        end
      end
      for (int k = 0; k < CMT_W; k++) begin
        if (cmt_v_o[k]) begin
          tidx         = head_q[RIDW-1:0] + RIDW'(k);
          v_d[tidx]    = 1'b0;
          done_d[tidx] = 1'b0;
        end
      end
      head_d = head_q + ncmt;
      if (alloc_go) begin
        tidx          = tail_q[RIDW-1:0];
        v_d[tidx]     = 1'b1;
        done_d[tidx]  = 1'b0;
        cause_d[tidx] = 8'h00;
        rt_d[tidx]    = alloc_rt_i;
        rfwr_d[tidx]  = alloc_rfwr_i;
        ip_d[tidx]    = alloc_ip_i;
        tail_d        = tail_q + (RIDW+1)'(1);
      end
    end
  end

  // State registers; reset empties the queue immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      v_q    <= '0;
      done_q <= '0;
      rfwr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        rt_q[i]    <= '0;
        cause_q[i] <= '0;
        ip_q[i]    <= '0;
        res_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      v_q     <= v_d;
      done_q  <= done_d;
      rfwr_q  <= rfwr_d;
      rt_q    <= rt_d;
      cause_q <= cause_d;
      ip_q    <= ip_d;
      res_q   <= res_d;
    end
  end

endmodule
